// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: widths, opcodes,
// mux select codes, state encodings and the control vector.
// Optional feature: MULTICYCLE_EXCEPTION_EN adds the EXCEPTION state and epc/cause writes.
package multicycle_control_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned OP_W    = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
`ifdef MULTICYCLE_EXCEPTION_EN
        , S_EXCEPTION = 4'd12
`endif
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
`ifdef MULTICYCLE_EXCEPTION_EN
        logic       epc_write;
        logic       cause_write;
`endif
    } ctrl_t;

    // True for opcodes the controller has a dedicated sequence for.
    function automatic logic is_known_op(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/memory handshake in, datapath enables and selects out.
// Optional feature: MULTICYCLE_EXCEPTION_EN adds epcWrite/causeWrite.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [OP_W-1:0]    opcode;
    logic               memReady;
    logic               pcWrite;
    logic               pcWriteCond;
    logic               iorD;
    logic               memRead;
    logic               memWrite;
    logic               irWrite;
    logic               memToReg;
    logic               regDst;
    logic               regWrite;
    logic               aluSrcA;
    logic [1:0]         aluSrcB;
    logic [1:0]         aluOp;
    logic [1:0]         pcSource;
    logic               instrDone;
    logic [CNT_W-1:0]   instrCount;
    logic [STATE_W-1:0] state;
`ifdef MULTICYCLE_EXCEPTION_EN
    logic               epcWrite;
    logic               causeWrite;
`endif

    modport master (
        input  opcode, memReady,
`ifdef MULTICYCLE_EXCEPTION_EN
        output epcWrite, causeWrite,
`endif
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
               instrDone, instrCount, state
    );

    modport slave (
        output opcode, memReady,
`ifdef MULTICYCLE_EXCEPTION_EN
        input  epcWrite, causeWrite,
`endif
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
               instrDone, instrCount, state
    );

endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational state -> control vector decode (Moore, with memReady gating in FETCH/MEM_WRITE).
// Optional feature: MULTICYCLE_EXCEPTION_EN (EXCEPTION state decode; unknown opcodes no longer retire in DECODE).
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  state_e          state_i,
`ifdef MULTICYCLE_EXCEPTION_EN
`else
    input  logic [OP_W-1:0] opcode_i,
`endif
    input  logic            mem_ready_i,
    output ctrl_t           ctrl_o
);

    // Control vector for the current state; everything idles at 0 unless listed.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_SEXT_SH;
`ifdef MULTICYCLE_EXCEPTION_EN
`else
                ctrl_o.instr_done = !is_known_op(opcode_i);
`endif
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_RT;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
`ifdef MULTICYCLE_EXCEPTION_EN
            S_EXCEPTION: begin
                ctrl_o.pc_write    = 1'b1;
                ctrl_o.pc_source   = PCSRC_EXC;
                ctrl_o.epc_write   = 1'b1;
                ctrl_o.cause_write = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller top: state register, next-state sequencing, retired-instruction counter.
// Optional feature: MULTICYCLE_EXCEPTION_EN routes unknown opcodes to an EXCEPTION state
// instead of retiring them as NOPs in DECODE.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    multicycle_control_if.master  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    ctrl_t            ctrl_c;
    ctrl_t            ctrl_out;

    multicycle_control_decode u_decode (
        .state_i     (state_q),
`ifdef MULTICYCLE_EXCEPTION_EN
`else
        .opcode_i    (bus.opcode),
`endif
        .mem_ready_i (bus.memReady),
        .ctrl_o      (ctrl_c)
    );

    // Next-state sequencing; memory states hold until memReady, everything else returns to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = bus.memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MULTICYCLE_EXCEPTION_EN
                    default:      state_d = S_EXCEPTION;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = bus.memReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = bus.memReady ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    assign count_d = count_q + CNT_W'(ctrl_c.instr_done);

    // State and retired-instruction counter; reset drops straight back to FETCH with a clear count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Hold every datapath enable low while reset is asserted.
    assign ctrl_out = reset ? '0 : ctrl_c;

    assign bus.pcWrite     = ctrl_out.pc_write;
    assign bus.pcWriteCond = ctrl_out.pc_write_cond;
    assign bus.iorD        = ctrl_out.iord;
    assign bus.memRead     = ctrl_out.mem_read;
    assign bus.memWrite    = ctrl_out.mem_write;
    assign bus.irWrite     = ctrl_out.ir_write;
    assign bus.memToReg    = ctrl_out.mem_to_reg;
    assign bus.regDst      = ctrl_out.reg_dst;
    assign bus.regWrite    = ctrl_out.reg_write;
    assign bus.aluSrcA     = ctrl_out.alu_src_a;
    assign bus.aluSrcB     = ctrl_out.alu_src_b;
    assign bus.aluOp       = ctrl_out.alu_op;
    assign bus.pcSource    = ctrl_out.pc_source;
    assign bus.instrDone   = ctrl_out.instr_done;
    assign bus.instrCount  = count_q;
    assign bus.state       = state_q;
`ifdef MULTICYCLE_EXCEPTION_EN
    assign bus.epcWrite    = ctrl_out.epc_write;
    assign bus.causeWrite  = ctrl_out.cause_write;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level model emits the expected
// per-cycle trace (state, controls, count); a monitor compares it on the falling edge.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       epc;
        logic       cause;
    } obs_t;

    typedef struct packed {
        logic [3:0]       st;
        obs_t             ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    exp_t             scb[$];
    logic [CNT_W-1:0] model_count;
    int               total  = 0;
    int               passed = 0;

    function automatic logic known(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t base(input logic [3:0] s);
        exp_t e;
        e.st  = s;
        e.ctl = '0;
        e.cnt = model_count;
        return e;
    endfunction

    // One clock of stimulus: drive inputs just after the edge and queue what that cycle should show.
    task automatic step(input exp_t e, input logic mr, input logic [5:0] op, input logic r);
        @(posedge clk);
        #1;
        rst          = r;
        bus.memReady = mr;
        bus.opcode   = op;
        scb.push_back(e);
    endtask

    task automatic retire(input exp_t e, input logic mr, input logic [5:0] op);
        e.ctl.instr_done = 1'b1;
        step(e, mr, op, 1'b0);
        model_count = model_count + 1'b1;
    endtask

    task automatic fetch(input int fw);
        exp_t e;
        for (int i = 0; i < fw; i++) begin
            e = base(4'd0);
            e.ctl.mem_read  = 1'b1;
            e.ctl.alu_src_b = 2'b01;
            step(e, 1'b0, 6'($urandom), 1'b0);
        end
        e = base(4'd0);
        e.ctl.mem_read  = 1'b1;
        e.ctl.alu_src_b = 2'b01;
        e.ctl.ir_write  = 1'b1;
        e.ctl.pc_write  = 1'b1;
        step(e, 1'b1, 6'($urandom), 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        model_count = '0;
        for (int i = 0; i < cycles; i++) step(base(4'd0), rb(), 6'($urandom), 1'b1);
    endtask

    // Full instruction: fetch (fw wait cycles), decode, class-specific tail (mw memory wait cycles).
    task automatic issue(input logic [5:0] op, input int fw, input int mw);
        exp_t e;
        fetch(fw);
        e = base(4'd1);
        e.ctl.alu_src_b = 2'b11;
        if (!known(op)) begin
`ifdef MULTICYCLE_EXCEPTION_EN
            step(e, rb(), op, 1'b0);
            e = base(4'd12);
            e.ctl.pc_write  = 1'b1;
            e.ctl.pc_source = 2'b11;
            e.ctl.epc       = 1'b1;
            e.ctl.cause     = 1'b1;
            step(e, rb(), op, 1'b0);
`else
            retire(e, rb(), op);
`endif
            return;
        end
        step(e, rb(), op, 1'b0);
        case (op)
            6'h23, 6'h2b: begin
                e = base(4'd2);
                e.ctl.alu_src_a = 1'b1;
                e.ctl.alu_src_b = 2'b10;
                step(e, rb(), op, 1'b0);
                e = base(op == 6'h23 ? 4'd3 : 4'd5);
                e.ctl.iord      = 1'b1;
                e.ctl.mem_read  = (op == 6'h23);
                e.ctl.mem_write = (op == 6'h2b);
                for (int i = 0; i < mw; i++) step(e, 1'b0, op, 1'b0);
                if (op == 6'h23) begin
                    step(e, 1'b1, op, 1'b0);
                    e = base(4'd4);
                    e.ctl.reg_write  = 1'b1;
                    e.ctl.mem_to_reg = 1'b1;
                    retire(e, rb(), op);
                end else begin
                    retire(e, 1'b1, op);
                end
            end
            6'h00: begin
                e = base(4'd6);
                e.ctl.alu_src_a = 1'b1;
                e.ctl.alu_op    = 2'b10;
                step(e, rb(), op, 1'b0);
                e = base(4'd7);
                e.ctl.reg_write = 1'b1;
                e.ctl.reg_dst   = 1'b1;
                retire(e, rb(), op);
            end
            6'h04: begin
                e = base(4'd8);
                e.ctl.alu_src_a     = 1'b1;
                e.ctl.alu_op        = 2'b01;
                e.ctl.pc_write_cond = 1'b1;
                e.ctl.pc_source     = 2'b01;
                retire(e, rb(), op);
            end
            6'h02: begin
                e = base(4'd9);
                e.ctl.pc_write  = 1'b1;
                e.ctl.pc_source = 2'b10;
                retire(e, rb(), op);
            end
            default: begin
                e = base(4'd10);
                e.ctl.alu_src_a = 1'b1;
                e.ctl.alu_src_b = 2'b10;
                step(e, rb(), op, 1'b0);
                e = base(4'd11);
                e.ctl.reg_write = 1'b1;
                retire(e, rb(), op);
            end
        endcase
    endtask

    // lw that is cut off by reset while waiting in MEM_READ.
    task automatic reset_in_mem_read();
        exp_t e;
        fetch(0);
        e = base(4'd1);
        e.ctl.alu_src_b = 2'b11;
        step(e, rb(), 6'h23, 1'b0);
        e = base(4'd2);
        e.ctl.alu_src_a = 1'b1;
        e.ctl.alu_src_b = 2'b10;
        step(e, rb(), 6'h23, 1'b0);
        e = base(4'd3);
        e.ctl.mem_read = 1'b1;
        e.ctl.iord     = 1'b1;
        step(e, 1'b0, 6'h23, 1'b0);
        do_reset(2);
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.pc_write      = bus.pcWrite;
        o.pc_write_cond = bus.pcWriteCond;
        o.iord          = bus.iorD;
        o.mem_read      = bus.memRead;
        o.mem_write     = bus.memWrite;
        o.ir_write      = bus.irWrite;
        o.mem_to_reg    = bus.memToReg;
        o.reg_dst       = bus.regDst;
        o.reg_write     = bus.regWrite;
        o.alu_src_a     = bus.aluSrcA;
        o.alu_src_b     = bus.aluSrcB;
        o.alu_op        = bus.aluOp;
        o.pc_source     = bus.pcSource;
        o.instr_done    = bus.instrDone;
`ifdef MULTICYCLE_EXCEPTION_EN
        o.epc           = bus.epcWrite;
        o.cause         = bus.causeWrite;
`else
        o.epc           = 1'b0;
        o.cause         = 1'b0;
`endif
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, want);
    endtask

    // Monitor: every falling edge with a queued expectation is compared against the DUT.
    initial begin
        forever begin
            @(negedge clk);
            if (scb.size() > 0) begin
                exp_t e;
                e = scb.pop_front();
                check("state", 64'(bus.state), 64'(e.st));
                check("controls", 64'(sample()), 64'(e.ctl));
                check("instrCount", 64'(bus.instrCount), 64'(e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [5:0] op;
        rst          = 1'b1;
        bus.memReady = 1'b0;
        bus.opcode   = '0;
        model_count  = '0;

        do_reset(2);
        issue(6'h00, 0, 0);
        issue(6'h23, 2, 2);
        issue(6'h2b, 0, 1);
        issue(6'h04, 0, 0);
        issue(6'h02, 1, 0);
        issue(6'h08, 0, 0);
        issue(6'h3f, 0, 0);
        reset_in_mem_read();
        issue(6'h00, 0, 0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2b;
                3: op = 6'h04;
                4: op = 6'h02;
                5: op = 6'h08;
                default: begin
                    op = 6'($urandom);
                    while (known(op)) op = 6'($urandom);
                end
            endcase
            issue(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 39) == 0) do_reset(1);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(scb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
